sha_digest_tx: RTL and testbench
================================

# sha_digest_tx

Digest serializer for the UART/SHA3 datapath. Captures the 512-bit SHA3-512 digest when the hashing block raises its output-valid, and streams the digest out one byte at a time over a valid/ready byte interface toward the UART transmitter. Sits between the `sha` block's `hash`/`out_valid` outputs and the UART TX byte input, and is the outbound counterpart of the word-feed path into the hash core.

## Interface
Parameters:
- none (digest width fixed at 512 bits)

Ports:
- `clk_i`  in  1  system clock; all logic on rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `hash_i`  in  512  digest; sampled only on capture
- `hash_valid_i`  in  1  level "digest valid"; capture on its rising edge
- `tx_data_o`  out  8  current output byte
- `tx_valid_o`  out  1  `tx_data_o` valid
- `tx_ready_i`  in  1  downstream accepts the byte this cycle
- `busy_o`  out  1  high from capture until end of DONE
- `done_o`  out  1  one-cycle pulse after the final byte handshake

## Operation
- Registers: 512-bit shift register `sr`, char counter `cnt` (7 bits), `hv_q` (previous `hash_valid_i`), state.
- Edge detect: `rise = hash_valid_i & ~hv_q`. `hv_q` updates every non-reset cycle, in every state.
- States:
  - IDLE: `tx_valid_o`=0, `busy_o`=0. On `rise`: `sr <= hash_i`, `cnt <= 0`, go to SEND.
  - SEND: `tx_valid_o`=1, `busy_o`=1. On `tx_valid_o & tx_ready_i`: if `cnt == LAST`, go to DONE; otherwise `cnt <= cnt+1` and advance `sr`.
  - DONE: `done_o`=1, `busy_o`=1, `tx_valid_o`=0. Go to IDLE the next cycle.
- Byte order: most significant first. The first byte is `hash_i[511:504]` and the last is `hash_i[7:0]`.
- `rise` seen in SEND or DONE is discarded; no queuing. A level held high never retriggers.
- Reset values: state IDLE, `tx_valid_o`=0, `tx_data_o`=8'h00, `busy_o`=0, `done_o`=0, `hv_q`=0, `cnt`=0, `sr`=0.
  - Because `hv_q` resets to 0, `hash_valid_i` high at the first post-reset cycle counts as a rise.
- Reset mid-transfer: abort immediately. The next cycle is IDLE with outputs at reset values, and the remaining bytes are dropped.

## Timing
- Capture at edge N, where `rise` is high in the cycle before N. `tx_valid_o`=1 with the first byte from cycle N.
- Throughput: one character per cycle while `tx_ready_i`=1.
- Handshake: while `tx_valid_o`=1 and `tx_ready_i`=0, `tx_data_o` is held stable. `tx_valid_o` never deasserts before the handshake, except on reset.
- Last handshake at edge M: DONE during cycle M→M+1 (`done_o`=1), IDLE from edge M+1.
- Minimum gap between two digests: one cycle in DONE plus a new rising edge seen in IDLE.

## Configuration
- Macro `SHA_DIGEST_HEX_EN`.
- Defined: output is ASCII lowercase hex, 128 characters, high nibble first.
  - Nibble 0-9 maps to 0x30-0x39; nibble a-f maps to 0x61-0x66.
  - LAST = 127; `sr` shifts by 4 bits per character.
- Undefined: output is raw binary, 64 bytes.
  - LAST = 63; `sr` shifts by 8 bits per byte.
  - Upper counter bit unused; `cnt` may be 6 bits.

## Test plan
- Raw mode, `hash_i` = bytes 0x01,0x02,…,0x40 (MSB first), `tx_ready_i`=1, pulse `hash_valid_i` → exactly 64 handshakes with data 0x01…0x40 in order, then `done_o` high for exactly 1 cycle, then `busy_o`=0.
- Backpressure: random `tx_ready_i` (~50%) on the same digest.
  - Each byte is held stable until accepted.
  - Sequence is unchanged, and the count stays at 64 (raw) or 128 (hex).
- Hex mode, `hash_i` = {64{8'hA5}} → 128 characters alternating 0x61 ('a'), 0x35 ('5'). With `hash_i[511:504]`=8'h0F, the first two characters are 0x30, 0x66.
- Retrigger: toggle `hash_valid_i` 0→1 with a new digest during SEND at byte 10.
  - Stream continues with the original digest, with no second transfer.
  - Holding `hash_valid_i` high after DONE produces no new transfer until it drops and rises again.
- Reset mid-transfer: assert `rst_i` for 1 cycle after byte 10 is accepted.
  - Next cycle: `tx_valid_o`=0, `busy_o`=0, `done_o`=0.
  - A subsequent rise restarts from byte 0 of the newly captured digest.
- Back-to-back: raise `hash_valid_i` during the DONE cycle and hold it → ignored. Lower it, then raise it in IDLE → capture and first byte valid on the next cycle.

Source files
------------

// File: rtl/sha_digest_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sha_digest_tx                                                   |
// | Purpose  : Captures a 512-bit SHA3-512 digest on the rising edge of        |
// |            hash_valid_i and streams it MSB-first over a valid/ready byte   |
// |            interface toward the UART transmitter.                          |
// | Options  : SHA_DIGEST_HEX_EN - when defined, emit 128 lowercase ASCII hex  |
// |            characters (high nibble first) instead of 64 raw bytes.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sha_digest_tx (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [511:0] hash_i,
  input  logic         hash_valid_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic         busy_o,
  output logic         done_o
);

`ifdef SHA_DIGEST_HEX_EN
  localparam int unsigned CHAR_BITS = 4;
  localparam logic [6:0]  LAST      = 7'd127;
`else
  localparam int unsigned CHAR_BITS = 8;
  localparam logic [6:0]  LAST      = 7'd63;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [511:0] sr;
  logic [6:0]   cnt;
  logic         hv_q;
  logic         rise;
  logic         capture;
  logic         advance;
  logic [7:0]   cur_char;

  // A level held high only counts once; hv_q remembers the previous cycle.
  assign rise = hash_valid_i & ~hv_q;

`ifdef SHA_DIGEST_HEX_EN
  logic [3:0] nib;
  assign nib = sr[511:508];
  // Map the leading nibble to lowercase ASCII hex ('0'-'9', 'a'-'f').
  always_comb begin
    cur_char = 8'h00;
    if (nib < 4'd10) cur_char = 8'h30 + {4'h0, nib};
    else             cur_char = 8'h57 + {4'h0, nib};
  end
`else
  assign cur_char = sr[511:504];
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and Moore/handshake outputs; data is forced to zero
  // outside SEND so the idle bus matches the reset value in both modes.
  always_comb begin
    state_next = state;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          capture    = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        tx_valid_o = 1'b1;
        busy_o     = 1'b1;
        tx_data_o  = cur_char;
        if (tx_ready_i) begin
          if (cnt == LAST) state_next = DONE;
          else             advance    = 1'b1;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        busy_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: edge-detect history, digest shift register and char counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hv_q <= 1'b0;
      sr   <= '0;
      cnt  <= '0;
    end else begin
      hv_q <= hash_valid_i;
      if (capture) begin
        sr  <= hash_i;
        cnt <= '0;
      end else if (advance) begin
        sr  <= sr << CHAR_BITS;
        cnt <= cnt + 7'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha_digest_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sha_digest_tx                                                |
// | Purpose  : Self-checking bench for sha_digest_tx; compares the accepted    |
// |            character stream against a digest-to-characters model.          |
// | Options  : SHA_DIGEST_HEX_EN selects the hex-character build.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sha_digest_tx;
`ifdef SHA_DIGEST_HEX_EN
  localparam int NCHAR = 128;
`else
  localparam int NCHAR = 64;
`endif
  localparam int BUDGET = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] hash;
  logic         hash_valid;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;

  int           tests = 0;
  int           fails = 0;
  logic [7:0]   got[$];
  int           stable_bad;
  bit           timed_out;
  logic [511:0] d, d2;

  sha_digest_tx dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .hash_i       (hash),
    .hash_valid_i (hash_valid),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Expected i-th character of a digest: raw byte or ASCII hex of a nibble.
  function automatic logic [7:0] exp_char(input logic [511:0] dg, input int i);
    logic [511:0] t;
    logic [3:0]   n;
`ifdef SHA_DIGEST_HEX_EN
    t = dg >> (508 - 4 * i);
    n = t[3:0];
    if (n < 4'd10) return 8'h30 + 8'(n);
    return 8'h61 + 8'(n) - 8'd10;
`else
    t = dg >> (504 - 8 * i);
    n = 4'h0;
    return t[7:0] | {4'h0, n};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_digest();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  // Raise hash_valid at a negedge; one cycle later the first char must be valid.
  task automatic pulse_capture(input logic [511:0] dg, input string tag);
    hash       = dg;
    hash_valid = 1'b1;
    @(negedge clk);
    hash_valid = 1'b0;
    check({tag, "_cap_valid"}, {31'd0, tx_valid}, 32'd1);
    check({tag, "_cap_busy"},  {31'd0, busy},     32'd1);
  endtask

  // Drive ready randomly, record accepted chars, watch stability under stall.
  task automatic collect(input int ready_pct, input int retrig_at,
                         input logic [511:0] retrig_d, input int abort_at);
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;
    int         cyc = 0;
    bit         rdy;
    got.delete();
    stable_bad = 0;
    timed_out  = 1'b0;
    while (done !== 1'b1) begin
      if (abort_at > 0 && got.size() == abort_at) break;
      if (cyc >= BUDGET) begin
        timed_out = 1'b1;
        break;
      end
      if (pv && !pr && !(tx_valid === 1'b1 && tx_data === pd)) stable_bad++;
      rdy      = ($urandom_range(99) < ready_pct);
      tx_ready = rdy;
      if (tx_valid === 1'b1 && rdy) begin
        got.push_back(tx_data);
        if (retrig_at > 0 && got.size() == retrig_at) begin
          hash       = retrig_d;
          hash_valid = 1'b1;
        end
      end
      pv = tx_valid;
      pd = tx_data;
      pr = rdy;
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
  endtask

  task automatic compare(input logic [511:0] dg, input string tag);
    check({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
    check({tag, "_count"},   got.size(),        NCHAR);
    check({tag, "_stable"},  stable_bad,        32'd0);
    for (int i = 0; i < got.size() && i < NCHAR; i++)
      check($sformatf("%s_char%0d", tag, i), {24'd0, got[i]}, {24'd0, exp_char(dg, i)});
  endtask

  // At the DONE cycle: check the pulse, optionally raise hash_valid, then idle.
  task automatic check_done(input bit hv_in_done, input string tag);
    check({tag, "_done_hi"},   {31'd0, done},     32'd1);
    check({tag, "_done_busy"}, {31'd0, busy},     32'd1);
    check({tag, "_done_nv"},   {31'd0, tx_valid}, 32'd0);
    if (hv_in_done) hash_valid = 1'b1;
    @(negedge clk);
    check({tag, "_post_done"}, {31'd0, done},     32'd0);
    check({tag, "_post_busy"}, {31'd0, busy},     32'd0);
    check({tag, "_post_nv"},   {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic idle_for(input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (tx_valid !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check({tag, "_stay_idle"}, bad, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    hash       = '0;
    hash_valid = 1'b0;
    tx_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_done",  {31'd0, done},     32'd0);
    check("rst_data",  {24'd0, tx_data},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_valid", {31'd0, tx_valid}, 32'd0);

    // Directed digest, ready always high.
`ifdef SHA_DIGEST_HEX_EN
    d = {64{8'hA5}};
`else
    for (int i = 0; i < 64; i++) d[511 - 8*i -: 8] = 8'(i + 1);
`endif
    pulse_capture(d, "dir");
    collect(100, 0, '0, 0);
    compare(d, "dir");
    check_done(1'b0, "dir");
`ifdef SHA_DIGEST_HEX_EN
    if (got.size() >= 2) begin
      check("hex_a", {24'd0, got[0]}, 32'h61);
      check("hex_5", {24'd0, got[1]}, 32'h35);
    end
    d[511:504] = 8'h0F;
    pulse_capture(d, "hex0f");
    collect(100, 0, '0, 0);
    compare(d, "hex0f");
    check_done(1'b0, "hex0f");
    if (got.size() >= 2) begin
      check("hex0f_c0", {24'd0, got[0]}, 32'h30);
      check("hex0f_c1", {24'd0, got[1]}, 32'h66);
    end
`else
    if (got.size() == 64) begin
      check("raw_first", {24'd0, got[0]},  32'h01);
      check("raw_last",  {24'd0, got[63]}, 32'h40);
    end
`endif

    // Same digest under ~50% backpressure.
    pulse_capture(d, "bp");
    collect(50, 0, '0, 0);
    compare(d, "bp");
    check_done(1'b0, "bp");

    // Random digests with varying backpressure.
    for (int k = 0; k < 3; k++) begin
      d = rand_digest();
      pulse_capture(d, $sformatf("rnd%0d", k));
      collect(30 + 30 * k, 0, '0, 0);
      compare(d, $sformatf("rnd%0d", k));
      check_done(1'b0, $sformatf("rnd%0d", k));
    end

    // Retrigger mid-stream with a new digest; held level must not retrigger.
    d  = rand_digest();
    d2 = rand_digest();
    pulse_capture(d, "retrig");
    collect(70, 10, d2, 0);
    compare(d, "retrig");
    check_done(1'b0, "retrig");
    idle_for(6, "retrig_hold");
    hash_valid = 1'b0;
    @(negedge clk);

    // Reset after the tenth char; hash_valid high right after reset is a rise.
    d  = rand_digest();
    d2 = rand_digest();
    pulse_capture(d, "abort");
    collect(80, 0, '0, 10);
    check("abort_count", got.size(), 32'd10);
    rst        = 1'b1;
    tx_ready   = 1'b0;
    hash       = d2;
    hash_valid = 1'b1;
    @(negedge clk);
    check("abort_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_busy",  {31'd0, busy},     32'd0);
    check("abort_done",  {31'd0, done},     32'd0);
    rst = 1'b0;
    @(negedge clk);
    hash_valid = 1'b0;
    check("restart_valid", {31'd0, tx_valid}, 32'd1);
    collect(60, 0, '0, 0);
    compare(d2, "restart");
    check_done(1'b0, "restart");

    // Rise during DONE is dropped; a fresh rise in IDLE starts the next one.
    d = rand_digest();
    pulse_capture(d, "b2b_a");
    collect(100, 0, '0, 0);
    compare(d, "b2b_a");
    check_done(1'b1, "b2b_a");
    idle_for(4, "b2b_ignored");
    hash_valid = 1'b0;
    @(negedge clk);
    d2 = rand_digest();
    pulse_capture(d2, "b2b_b");
    collect(60, 0, '0, 0);
    compare(d2, "b2b_b");
    check_done(1'b0, "b2b_b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
